rx_fsm: RTL and testbench

RX_FSM -- requirements
Module: rx_fsm

---
 rtl/rx_fsm.sv | 77 +++++++
 tb/tb_rx_fsm.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/rx_fsm.sv
// rx_fsm: PCIe RX TLP sequencer steering header/payload beats into OCP engine registers
module rx_fsm #(
    parameter int keep_width = 8
) (
    input  logic                  rx_reset,
    input  logic                  rx_clk,
    input  logic                  rx_valid,
    input  logic [keep_width-1:0] rx_keep,
    input  logic                  rx_last,
    output logic                  rx_ready,
    input  logic                  tx_header_fifo_ready,
    output logic                  tx_header_fifo_valid,
    input  logic                  ocp_ready,
    input  logic [1:0]            optype,
    output logic [2:0]            ocp_reg_ctl
);
    typedef enum logic [1:0] {S_IDLE, S_HDR2, S_PAYLOAD, S_CPL} state_t;
    localparam logic [2:0] CTL_IDLE  = 3'b000;
    localparam logic [2:0] CTL_H1    = 3'b001;
    localparam logic [2:0] CTL_H2    = 3'b010;
    localparam logic [2:0] CTL_DATA3 = 3'b011;
    localparam logic [2:0] CTL_DATA4 = 3'b100;
    state_t     state, state_nxt;
    logic [1:0] optype_q, optype_nxt;
    logic       unused_keep;
    assign unused_keep = ^rx_keep;
    // state and latched TLP class; reset abandons any TLP in flight
    always_ff @(posedge rx_clk or posedge rx_reset) begin
        if (rx_reset) begin
            state    <= S_IDLE;
            optype_q <= 2'b00;
        end else begin
            state    <= state_nxt;
            optype_q <= optype_nxt;
        end
    end
    // next state and combinational handshake/register-select outputs; all quiet while in reset
    always_comb begin
        state_nxt            = state;
        optype_nxt           = optype_q;
        rx_ready             = 1'b0;
        tx_header_fifo_valid = 1'b0;
        ocp_reg_ctl          = CTL_IDLE;
        if (!rx_reset) begin
            case (state)
                S_IDLE: begin
                    rx_ready = 1'b1;
                    if (rx_valid) begin
                        ocp_reg_ctl = CTL_H1;
                        state_nxt   = rx_last ? S_IDLE : S_HDR2;
                    end
                end
                S_HDR2: begin
                    rx_ready = 1'b1;
                    if (rx_valid) begin
                        ocp_reg_ctl = CTL_H2;
                        optype_nxt  = optype;
                        state_nxt   = !rx_last ? S_PAYLOAD : (optype == 2'b00) ? S_CPL : S_IDLE;
                    end
                end
                S_PAYLOAD: begin
                    rx_ready = ocp_ready;
                    if (rx_valid && ocp_ready) begin
                        ocp_reg_ctl = (optype_q == 2'b01) ? CTL_DATA3 :
                                      (optype_q == 2'b10) ? CTL_DATA4 : CTL_IDLE;
                        state_nxt   = rx_last ? S_IDLE : S_PAYLOAD;
                    end
                end
                S_CPL: begin
                    tx_header_fifo_valid = 1'b1;
                    state_nxt            = tx_header_fifo_ready ? S_IDLE : S_CPL;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rx_fsm.sv
// tb_rx_fsm: directed vector table plus hand sequences for stalls, completion hold and async reset
module tb_rx_fsm;
    logic       rx_reset = 1'b1;
    logic       rx_clk = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_keep = 8'h00;
    logic       rx_last = 1'b0;
    logic       rx_ready;
    logic       tx_header_fifo_ready = 1'b0;
    logic       tx_header_fifo_valid;
    logic       ocp_ready = 1'b0;
    logic [1:0] optype = 2'b00;
    logic [2:0] ocp_reg_ctl;
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       rst, v, l, fr, ordy;
        logic [1:0] op;
        logic       rdy, fv;
        logic [2:0] ctl;
    } vec_t;
    vec_t tv[$];

    always #5 rx_clk = ~rx_clk;

    rx_fsm #(.keep_width(8)) dut (
        .rx_reset(rx_reset), .rx_clk(rx_clk), .rx_valid(rx_valid), .rx_keep(rx_keep),
        .rx_last(rx_last), .rx_ready(rx_ready), .tx_header_fifo_ready(tx_header_fifo_ready),
        .tx_header_fifo_valid(tx_header_fifo_valid), .ocp_ready(ocp_ready), .optype(optype),
        .ocp_reg_ctl(ocp_reg_ctl)
    );

    function automatic void add(input logic rst, v, l, fr, ordy, input logic [1:0] op,
                                input logic rdy, fv, input logic [2:0] ctl);
        vec_t t;
        t.rst = rst; t.v = v; t.l = l; t.fr = fr; t.ordy = ordy; t.op = op;
        t.rdy = rdy; t.fv = fv; t.ctl = ctl;
        tv.push_back(t);
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, v, l, fr, ordy, input logic [1:0] op);
        @(negedge rx_clk);
        rx_reset = rst; rx_valid = v; rx_last = l;
        tx_header_fifo_ready = fr; ocp_ready = ordy; optype = op;
        rx_keep = 8'($urandom);
    endtask

    initial begin
        int c;
        //  rst v  l  fr or op      rdy fv ctl
        add(1, 1, 0, 0, 1, 2'b00,  0, 0, 3'd0); // in reset
        add(1, 0, 0, 0, 0, 2'b00,  0, 0, 3'd0);
        add(0, 0, 0, 0, 0, 2'b00,  1, 0, 3'd0); // first cycle after release
        add(0, 1, 0, 0, 0, 2'b11,  1, 0, 3'd1); // read: H1
        add(0, 1, 1, 0, 0, 2'b00,  1, 0, 3'd2); // H2 last -> CPL
        add(0, 0, 0, 0, 0, 2'b00,  0, 1, 3'd0);
        add(0, 1, 0, 0, 1, 2'b00,  0, 1, 3'd0); // valid ignored in CPL
        add(0, 0, 0, 1, 0, 2'b00,  0, 1, 3'd0); // fifo takes header
        add(0, 0, 0, 0, 0, 2'b00,  1, 0, 3'd0);
        add(0, 1, 0, 0, 0, 2'b00,  1, 0, 3'd1); // 3DW write
        add(0, 1, 0, 0, 0, 2'b01,  1, 0, 3'd2);
        add(0, 1, 0, 0, 1, 2'b00,  1, 0, 3'd3);
        add(0, 1, 1, 0, 1, 2'b10,  1, 0, 3'd3);
        add(0, 0, 0, 1, 1, 2'b00,  1, 0, 3'd0);
        add(0, 1, 0, 0, 1, 2'b00,  1, 0, 3'd1); // 4DW write with stall
        add(0, 1, 0, 0, 1, 2'b10,  1, 0, 3'd2);
        add(0, 1, 1, 0, 0, 2'b00,  0, 0, 3'd0);
        add(0, 1, 1, 0, 0, 2'b00,  0, 0, 3'd0);
        add(0, 1, 1, 0, 1, 2'b00,  1, 0, 3'd4);
        add(0, 0, 0, 0, 1, 2'b00,  1, 0, 3'd0);
        add(0, 1, 0, 0, 1, 2'b00,  1, 0, 3'd1); // bubbles between headers
        add(0, 0, 0, 0, 1, 2'b00,  1, 0, 3'd0);
        add(0, 0, 1, 0, 1, 2'b00,  1, 0, 3'd0);
        add(0, 0, 0, 1, 0, 2'b00,  1, 0, 3'd0);
        add(0, 1, 1, 0, 1, 2'b01,  1, 0, 3'd2); // write ending at H2 -> IDLE
        add(0, 0, 0, 0, 1, 2'b00,  1, 0, 3'd0);
        add(0, 1, 0, 0, 1, 2'b00,  1, 0, 3'd1); // unsupported
        add(0, 1, 0, 0, 1, 2'b11,  1, 0, 3'd2);
        add(0, 1, 0, 0, 1, 2'b01,  1, 0, 3'd0);
        add(0, 1, 1, 0, 1, 2'b10,  1, 0, 3'd0);
        add(0, 0, 0, 0, 1, 2'b00,  1, 0, 3'd0);
        add(0, 1, 0, 0, 1, 2'b00,  1, 0, 3'd1); // read with payload: no completion
        add(0, 1, 0, 0, 1, 2'b00,  1, 0, 3'd2);
        add(0, 1, 1, 0, 1, 2'b01,  1, 0, 3'd0);
        add(0, 0, 0, 1, 1, 2'b00,  1, 0, 3'd0);
        add(0, 1, 1, 0, 1, 2'b00,  1, 0, 3'd1); // runt stays idle
        add(0, 1, 0, 0, 1, 2'b00,  1, 0, 3'd1);
        add(0, 1, 1, 0, 1, 2'b00,  1, 0, 3'd2); // -> CPL
        add(0, 0, 0, 0, 1, 2'b00,  0, 1, 3'd0);
        add(1, 0, 0, 0, 1, 2'b00,  0, 0, 3'd0); // reset in CPL
        add(0, 0, 0, 0, 1, 2'b00,  1, 0, 3'd0);
        add(0, 1, 0, 0, 1, 2'b00,  1, 0, 3'd1);
        add(1, 1, 0, 0, 1, 2'b00,  0, 0, 3'd0); // reset mid-TLP
        add(0, 1, 0, 0, 1, 2'b00,  1, 0, 3'd1); // next beat is H1 again
        add(0, 1, 1, 0, 1, 2'b01,  1, 0, 3'd2);
        add(0, 0, 0, 0, 1, 2'b00,  1, 0, 3'd0);
        foreach (tv[i]) begin
            drive(tv[i].rst, tv[i].v, tv[i].l, tv[i].fr, tv[i].ordy, tv[i].op);
            #1;
            chk("rx_ready", i, int'(rx_ready), int'(tv[i].rdy));
            chk("fifo_valid", i, int'(tx_header_fifo_valid), int'(tv[i].fv));
            chk("ocp_reg_ctl", i, int'(ocp_reg_ctl), int'(tv[i].ctl));
        end
        // completion held for several cycles, then released with bounded wait
        drive(0, 1, 0, 0, 1, 2'b00);
        drive(0, 1, 1, 0, 1, 2'b00);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 0, 1, 2'b00);
            #1;
            chk("cpl_hold_fv", 100 + i, int'(tx_header_fifo_valid), 1);
            chk("cpl_hold_rdy", 100 + i, int'(rx_ready), 0);
        end
        drive(0, 0, 0, 1, 1, 2'b00);
        c = 0;
        while (tx_header_fifo_valid && c < 10) begin
            @(posedge rx_clk);
            #1;
            c++;
        end
        chk("cpl_exit_cycles", 110, c, 1);
        chk("cpl_exit_rdy", 111, int'(rx_ready), 1);
        // async reset asserted between clock edges while in CPL
        drive(0, 1, 0, 0, 1, 2'b00);
        drive(0, 1, 1, 0, 1, 2'b00);
        @(posedge rx_clk);
        #3;
        chk("pre_async_fv", 120, int'(tx_header_fifo_valid), 1);
        rx_reset = 1'b1;
        #1;
        chk("async_fv", 121, int'(tx_header_fifo_valid), 0);
        chk("async_rdy", 122, int'(rx_ready), 0);
        chk("async_ctl", 123, int'(ocp_reg_ctl), 0);
        drive(0, 1, 0, 0, 1, 2'b00);
        #1;
        chk("post_rst_rdy", 124, int'(rx_ready), 1);
        chk("post_rst_ctl", 125, int'(ocp_reg_ctl), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
